// File: rtl/ternary_serial_subtractor_if.sv
//------------------------------------------------------------------------------
// ternary_serial_subtractor_if
// Operand/result bus and start/busy/done handshake for the ternary subtractor.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ternary_serial_subtractor_if #(
  parameter int N = 4
);
  logic           start;
  logic [2*N-1:0] x;
  logic [2*N-1:0] y;
  logic           bIn;
  logic [2*N-1:0] d;
  logic           bOut;
  logic           err;
  logic           busy;
  logic           done;

  modport master (
    output start, x, y, bIn,
    input  d, bOut, err, busy, done
  );

  modport slave (
    input  start, x, y, bIn,
    output d, bOut, err, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/ternary_serial_subtractor.sv
//------------------------------------------------------------------------------
// ternary_serial_subtractor
// Digit-serial D = X - Y - bIn over N trits, LSD first, one trit per clock.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ternary_serial_subtractor #(
  parameter int N = 4
) (
  input wire logic                  clk,
  input wire logic                  rst,
  ternary_serial_subtractor_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [2*N-1:0] x_q;
  logic [2*N-1:0] y_q;
  logic [2*N-1:0] d_q;
  logic [CW-1:0]  cnt_q;
  logic           bw_q;
  logic           bout_q;
  logic           err_q;
  logic           busy_q;
  logic           done_q;

  logic [1:0]     trit_a;
  logic [1:0]     trit_b;
  logic [3:0]     diff;
  logic [1:0]     digit_d;
  logic           borrow_d;
  logic           trit_bad;

  // diff spans -3..2 in 4-bit two's complement; bit 3 flags a borrow.
  always_comb begin
    trit_a   = x_q[2*cnt_q +: 2];
    trit_b   = y_q[2*cnt_q +: 2];
    trit_bad = (trit_a == 2'b11) || (trit_b == 2'b11);
    diff     = {2'b00, trit_a} - {2'b00, trit_b} - {3'b000, bw_q};
    digit_d  = diff[3] ? (diff[1:0] + 2'd3) : diff[1:0];
    borrow_d = diff[3];
    if (trit_bad) begin
      digit_d  = 2'b11;
      borrow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      bw_q    <= 1'b0;
      bout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (bus.start) begin
            x_q     <= bus.x;
            y_q     <= bus.y;
            bw_q    <= bus.bIn;
            d_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          d_q[2*cnt_q +: 2] <= digit_d;
          bw_q              <= borrow_d;
          err_q             <= err_q | trit_bad;
          if (cnt_q == CW'(N - 1)) begin
            cnt_q   <= '0;
            bout_q  <= borrow_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.d    = d_q;
  assign bus.bOut = bout_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ternary_serial_subtractor.sv
//------------------------------------------------------------------------------
// tb_ternary_serial_subtractor
// Self-checking bench: directed cases plus random operands against a numeric model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ternary_serial_subtractor;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  ternary_serial_subtractor_if #(.N(N)) bus ();

  ternary_serial_subtractor #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Valid operands: plain integer subtraction modulo 3^N. Invalid trits break
  // the chain (digit 11, borrow 0), so that case walks the digits.
  task automatic model(input logic [7:0] xv, input logic [7:0] yv, input logic bv,
                       output logic [7:0] dv, output logic bo, output logic er);
    int xi, yi, p, df, ta, tb, bw;
    er = 1'b0;
    dv = '0;
    for (int i = 0; i < N; i++)
      if (xv[2*i +: 2] == 2'b11 || yv[2*i +: 2] == 2'b11) er = 1'b1;
    if (!er) begin
      xi = 0; yi = 0; p = 1;
      for (int i = 0; i < N; i++) begin
        xi += int'(xv[2*i +: 2]) * p;
        yi += int'(yv[2*i +: 2]) * p;
        p  *= 3;
      end
      df = xi - yi - int'(bv);
      bo = (df < 0);
      if (bo) df += p;
      for (int i = 0; i < N; i++) begin
        dv[2*i +: 2] = 2'(df % 3);
        df /= 3;
      end
    end else begin
      bw = int'(bv);
      for (int i = 0; i < N; i++) begin
        ta = int'(xv[2*i +: 2]);
        tb = int'(yv[2*i +: 2]);
        if (ta == 3 || tb == 3) begin
          dv[2*i +: 2] = 2'b11;
          bw = 0;
        end else begin
          df = ta - tb - bw;
          bw = (df < 0) ? 1 : 0;
          dv[2*i +: 2] = 2'((df < 0) ? df + 3 : df);
        end
      end
      bo = 1'(bw);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge (edge T).
  // mode 1: extra start 2 cycles in (must be ignored); mode 2: rst in 3rd RUN cycle.
  task automatic run_op(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                        input logic bv, input int mode);
    logic [7:0] ed;
    logic       eb, ee;
    int         cyc;
    model(xv, yv, bv, ed, eb, ee);
    bus.x = xv; bus.y = yv; bus.bIn = bv; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.x = ~xv; bus.y = ~yv; bus.bIn = ~bv;
    check_val({tag, ":d_cleared"}, 32'(bus.d[1:0]), 32'd0);
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      check_val({tag, ":busy"}, 32'(bus.busy), 32'd1);
      if (mode == 1 && cyc == 1) begin
        bus.start = 1'b1; bus.x = 8'h55; bus.y = 8'h00; bus.bIn = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (mode == 2 && cyc == 2) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val({tag, ":abort_busy"}, 32'(bus.busy), 32'd0);
        check_val({tag, ":abort_d"}, 32'(bus.d), 32'd0);
        check_val({tag, ":abort_bOut"}, 32'(bus.bOut), 32'd0);
        check_val({tag, ":abort_err"}, 32'(bus.err), 32'd0);
        cyc = 0;
        repeat (8) begin
          @(negedge clk);
          if (bus.done) cyc++;
        end
        check_val({tag, ":abort_nodone"}, 32'(cyc), 32'd0);
        return;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check_val({tag, ":latency"}, 32'(cyc), 32'(N));
    check_val({tag, ":busy_in_done"}, 32'(bus.busy), 32'd0);
    check_val({tag, ":d"}, 32'(bus.d), 32'(ed));
    check_val({tag, ":bOut"}, 32'(bus.bOut), 32'(eb));
    check_val({tag, ":err"}, 32'(bus.err), 32'(ee));
  endtask

  initial begin
    logic [7:0] rx, ry;
    bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.bIn = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_d", 32'(bus.d), 32'd0);
    check_val("rst_bOut", 32'(bus.bOut), 32'd0);
    check_val("rst_err", 32'(bus.err), 32'd0);

    @(negedge clk);
    run_op("basic", 8'b01100100, 8'b00010010, 1'b0, 0);
    check_val("basic_const_d", 32'(bus.d), 32'h51);
    @(negedge clk);
    run_op("under", 8'h00, 8'h01, 1'b0, 0);
    check_val("under_const_d", 32'(bus.d), 32'hAA);
    check_val("under_const_b", 32'(bus.bOut), 32'd1);
    repeat (3) @(negedge clk);
    check_val("hold_d", 32'(bus.d), 32'hAA);
    check_val("hold_bOut", 32'(bus.bOut), 32'd1);
    check_val("hold_done", 32'(bus.done), 32'd0);
    run_op("bin1", 8'h01, 8'h00, 1'b1, 0);
    @(negedge clk);
    run_op("bin0", 8'h00, 8'h00, 1'b1, 0);
    @(negedge clk);
    run_op("inval", 8'b00110000, 8'h00, 1'b0, 0);
    check_val("inval_trit2", 32'(bus.d[5:4]), 32'd3);
    @(negedge clk);
    run_op("clr_err", 8'h12, 8'h01, 1'b0, 0);
    @(negedge clk);
    run_op("ignored", 8'h26, 8'h11, 1'b0, 1);
    run_op("b2b", 8'h29, 8'h16, 1'b1, 0);
    run_op("prep", 8'h00, 8'h02, 1'b0, 0);
    @(negedge clk);
    run_op("abort", 8'h21, 8'h12, 1'b0, 2);

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N; i++) begin
        if (k % 5 == 4) begin
          rx[2*i +: 2] = 2'($urandom_range(0, 3));
          ry[2*i +: 2] = 2'($urandom_range(0, 3));
        end else begin
          rx[2*i +: 2] = 2'($urandom_range(0, 2));
          ry[2*i +: 2] = 2'($urandom_range(0, 2));
        end
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_op("rand", rx, ry, 1'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
